// File: rtl/jelly2_img_delay_var.sv
// Runtime-programmable delay line for the jelly2 image stream.
// Frame flags, pixel data and user sideband are carried through L cke cycles,
// where L is taken from param_latency only at a frame start so that a frame
// is never split across two latencies.
module jelly2_img_delay_var #(
  parameter int USER_WIDTH    = 0,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_LATENCY   = 16,
  parameter int LATENCY_WIDTH = $clog2(MAX_LATENCY + 1),
  parameter int INIT_LATENCY  = 1,
  parameter int USE_VALID     = 0,
  localparam int USER_BITS    = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,

  input  logic [LATENCY_WIDTH-1:0] param_latency,
  output logic [LATENCY_WIDTH-1:0] current_latency,

  input  logic                     s_img_row_first,
  input  logic                     s_img_row_last,
  input  logic                     s_img_col_first,
  input  logic                     s_img_col_last,
  input  logic                     s_img_de,
  input  logic [DATA_WIDTH-1:0]    s_img_data,
  input  logic [USER_BITS-1:0]     s_img_user,
  input  logic                     s_img_valid,

  output logic                     m_img_row_first,
  output logic                     m_img_row_last,
  output logic                     m_img_col_first,
  output logic                     m_img_col_last,
  output logic                     m_img_de,
  output logic [DATA_WIDTH-1:0]    m_img_data,
  output logic [USER_BITS-1:0]     m_img_user,
  output logic                     m_img_valid
);

  localparam int          PTR_W = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;
  localparam int          PIX_W = 5 + USER_BITS + DATA_WIDTH;
  localparam int unsigned MAX_U = MAX_LATENCY;

  // Map a requested latency onto the legal range 1..MAX_LATENCY.
  function automatic logic [LATENCY_WIDTH-1:0] clamp_lat(input int unsigned v);
    if (v == 0) begin
      return LATENCY_WIDTH'(1);
    end else if (v > MAX_U) begin
      return LATENCY_WIDTH'(MAX_U);
    end else begin
      return LATENCY_WIDTH'(v);
    end
  endfunction

  localparam logic [LATENCY_WIDTH-1:0] LAT_RESET = clamp_lat(INIT_LATENCY);

  // Everything except valid travels as one packed word through the buffer.
  logic [PIX_W-1:0]         pix_in;
  logic [PIX_W-1:0]         mem_q [MAX_LATENCY];
  logic [MAX_LATENCY-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]         wp_q, wp_d, rd_idx;
  logic [LATENCY_WIDTH-1:0] lat_q, lat_d, lat_req, lat_eff;
  logic                     frame_start, update;
  logic                     out_valid_q, out_valid_d;
  logic [PIX_W-1:0]         out_pix_q, out_pix_d;
  logic                     out_gate;
  int unsigned              wp_i, lm1_i, rd_i;

  assign pix_in = {s_img_row_first, s_img_row_last, s_img_col_first,
                   s_img_col_last, s_img_de, s_img_user, s_img_data};

  // Decide the latency for this edge; a differing request only lands on a frame start.
  always_comb begin
    frame_start = s_img_valid & s_img_de & s_img_row_first & s_img_col_first;
    lat_req     = clamp_lat(32'(param_latency));
    update      = frame_start && (lat_req != lat_q);
    lat_eff     = update ? lat_req : lat_q;
  end

  // Read slot holding the sample written L-1 cke edges ago (modulo buffer size).
  always_comb begin
    wp_i  = 32'(wp_q);
    lm1_i = 32'(lat_eff) - 1;
    if (wp_i >= lm1_i) begin
      rd_i = wp_i - lm1_i;
    end else begin
      rd_i = wp_i + MAX_U - lm1_i;
    end
    rd_idx = PTR_W'(rd_i);
  end

  // Next-state for pointer, valid bits, latency and the output register.
  always_comb begin
    lat_d       = lat_q;
    wp_d        = wp_q;
    valid_d     = valid_q;
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    if (cke) begin
      lat_d = lat_eff;
      if (update) begin
        valid_d = '0;
      end
      valid_d[wp_q] = s_img_valid;
      wp_d = (32'(wp_q) == MAX_U - 1) ? '0 : wp_q + 1'b1;
      if (lat_eff == LATENCY_WIDTH'(1)) begin
        // Single-stage delay: the output register takes the input directly.
        out_valid_d = s_img_valid;
        out_pix_d   = pix_in;
      end else begin
        // After a flush the read slot is never the one just written, so valid is 0.
        out_valid_d = update ? 1'b0 : valid_q[rd_idx];
        out_pix_d   = mem_q[rd_idx];
      end
    end
  end

  // Control state with synchronous reset, which acts regardless of cke.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_q       <= LAT_RESET;
      wp_q        <= '0;
      valid_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      lat_q       <= lat_d;
      wp_q        <= wp_d;
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload storage: no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (cke) begin
      mem_q[wp_q] <= pix_in;
    end
    out_pix_q <= out_pix_d;
  end

  assign out_gate        = (USE_VALID != 0) ? 1'b1 : out_valid_q;
  assign current_latency = lat_q;
  assign m_img_valid     = out_valid_q;
  assign m_img_data      = out_pix_q[DATA_WIDTH-1:0];
  assign m_img_user      = out_pix_q[DATA_WIDTH +: USER_BITS];
  assign m_img_de        = out_pix_q[DATA_WIDTH + USER_BITS]     & out_gate;
  assign m_img_col_last  = out_pix_q[DATA_WIDTH + USER_BITS + 1] & out_gate;
  assign m_img_col_first = out_pix_q[DATA_WIDTH + USER_BITS + 2] & out_gate;
  assign m_img_row_last  = out_pix_q[DATA_WIDTH + USER_BITS + 3] & out_gate;
  assign m_img_row_first = out_pix_q[DATA_WIDTH + USER_BITS + 4] & out_gate;

endmodule

// File: tb/tb_jelly2_img_delay_var.sv
// Bench for jelly2_img_delay_var: two instances (gated and raw flags) share
// the stimulus; a history-based model predicts every output each cycle.
module tb_jelly2_img_delay_var;

  localparam int DW    = 8;
  localparam int UW    = 3;
  localparam int MAXL  = 16;
  localparam int LW    = 5;
  localparam int INIT  = 1;
  localparam int HSIZE = 2048;

  logic clk = 1'b0;
  logic reset, cke;
  logic [LW-1:0] param_latency;
  logic s_rf, s_rl, s_cf, s_cl, s_de, s_valid;
  logic [DW-1:0] s_data;
  logic [UW-1:0] s_user;

  logic [LW-1:0] cur0, cur1;
  logic m0_rf, m0_rl, m0_cf, m0_cl, m0_de, m0_valid;
  logic m1_rf, m1_rl, m1_cf, m1_cl, m1_de, m1_valid;
  logic [DW-1:0] m0_data, m1_data;
  logic [UW-1:0] m0_user, m1_user;

  always #5 clk = ~clk;

  jelly2_img_delay_var #(
    .USER_WIDTH(UW), .DATA_WIDTH(DW), .MAX_LATENCY(MAXL),
    .LATENCY_WIDTH(LW), .INIT_LATENCY(INIT), .USE_VALID(0)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .param_latency(param_latency), .current_latency(cur0),
    .s_img_row_first(s_rf), .s_img_row_last(s_rl),
    .s_img_col_first(s_cf), .s_img_col_last(s_cl), .s_img_de(s_de),
    .s_img_data(s_data), .s_img_user(s_user), .s_img_valid(s_valid),
    .m_img_row_first(m0_rf), .m_img_row_last(m0_rl),
    .m_img_col_first(m0_cf), .m_img_col_last(m0_cl), .m_img_de(m0_de),
    .m_img_data(m0_data), .m_img_user(m0_user), .m_img_valid(m0_valid)
  );

  jelly2_img_delay_var #(
    .USER_WIDTH(UW), .DATA_WIDTH(DW), .MAX_LATENCY(MAXL),
    .LATENCY_WIDTH(LW), .INIT_LATENCY(INIT), .USE_VALID(1)
  ) dut_v (
    .clk(clk), .reset(reset), .cke(cke),
    .param_latency(param_latency), .current_latency(cur1),
    .s_img_row_first(s_rf), .s_img_row_last(s_rl),
    .s_img_col_first(s_cf), .s_img_col_last(s_cl), .s_img_de(s_de),
    .s_img_data(s_data), .s_img_user(s_user), .s_img_valid(s_valid),
    .m_img_row_first(m1_rf), .m_img_row_last(m1_rl),
    .m_img_col_first(m1_cf), .m_img_col_last(m1_cl), .m_img_de(m1_de),
    .m_img_data(m1_data), .m_img_user(m1_user), .m_img_valid(m1_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: history of accepted samples ----------------
  typedef struct {
    logic v, de, rf, rl, cf, cl;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
  } samp_t;

  samp_t hist [HSIZE];
  int e       = 0;   // cke edges since reset
  int floor_e = 0;   // first edge whose sample survives the last flush
  int cur_l   = 1;

  function automatic int clampm(input int v);
    if (v == 0) return 1;
    if (v > MAXL) return MAXL;
    return v;
  endfunction

  // Output after edge n is the sample from edge n-L+1, if it postdates the last flush/reset.
  always @(posedge clk) begin
    if (reset) begin
      e       = 0;
      floor_e = 0;
      cur_l   = clampm(INIT);
    end else if (cke) begin
      if (s_valid && s_de && s_rf && s_cf && clampm(32'(param_latency)) != cur_l) begin
        cur_l   = clampm(32'(param_latency));
        floor_e = e;
      end
      if (e < HSIZE) begin
        hist[e].v  = s_valid;
        hist[e].de = s_de;
        hist[e].rf = s_rf;
        hist[e].rl = s_rl;
        hist[e].cf = s_cf;
        hist[e].cl = s_cl;
        hist[e].d  = s_data;
        hist[e].u  = s_user;
      end
      e++;
    end
  end

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    int src;
    logic in_range, exp_v;
    logic [4:0] raw, act0, act1;
    #1;
    src      = e - cur_l;
    in_range = (e > 0) && (src >= floor_e) && (src < HSIZE);
    exp_v    = 1'b0;
    raw      = 5'b0;
    if (in_range) begin
      exp_v = hist[src].v;
      raw   = {hist[src].rf, hist[src].rl, hist[src].cf, hist[src].cl, hist[src].de};
    end
    act0 = {m0_rf, m0_rl, m0_cf, m0_cl, m0_de};
    act1 = {m1_rf, m1_rl, m1_cf, m1_cl, m1_de};
    check("lat0", 32'(cur0), 32'(cur_l));
    check("lat1", 32'(cur1), 32'(cur_l));
    check("valid0", 32'(m0_valid), 32'(exp_v));
    check("valid1", 32'(m1_valid), 32'(exp_v));
    check("flags_gated", 32'(act0), 32'(raw & {5{exp_v}}));
    if (in_range) begin
      check("flags_raw", 32'(act1), 32'(raw));
      check("data0", 32'(m0_data), 32'(hist[src].d));
      check("data1", 32'(m1_data), 32'(hist[src].d));
      check("user0", 32'(m0_user), 32'(hist[src].u));
      check("user1", 32'(m1_user), 32'(hist[src].u));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic de, input logic rf, input logic rl,
                       input logic cf, input logic cl, input int d);
    s_valid = v;
    s_de    = de;
    s_rf    = rf;
    s_rl    = rl;
    s_cf    = cf;
    s_cl    = cl;
    s_data  = DW'(d);
    s_user  = UW'(d);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    int ce;
    reset = 1'b1;
    cke   = 1'b1;
    param_latency = LW'(4);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_lat", 32'(cur0), 1);
    check("rst_valid", 32'(m0_valid), 0);
    reset = 1'b0;

    // Fixed latency 4 across several pointer wraps
    for (int i = 0; i < 60; i++) begin
      drive(1, 1, (i < 10), 0, (i % 10 == 0), (i % 10 == 9), i);
      step();
      if (i == 0) check("t1_lat", 32'(cur0), 4);
      if (i == 2) check("t1_pre_valid", 32'(m0_valid), 0);
      if (i == 3) begin
        check("t1_first_valid", 32'(m0_valid), 1);
        check("t1_first_data", 32'(m0_data), 0);
      end
      if (i == 50) check("t1_wrap_data", 32'(m0_data), 47);
    end
    param_latency = LW'(3);
    idle(4);

    // cke stall at latency 3
    ce = 0;
    for (int j = 0; j < 20; j++) begin
      if (j >= 10 && j < 15) begin
        cke = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 8'hAA);
      end else begin
        cke = 1'b1;
        drive(1, 1, (ce == 0), 0, (ce == 0), 0, 100 + ce);
        ce++;
      end
      step();
      if (j == 1) check("t2_flush_valid", 32'(m0_valid), 0);
      if (j == 2) check("t2_first_data", 32'(m0_data), 100);
      if (j == 9) check("t2_prestall_data", 32'(m0_data), 107);
      if (j == 12) begin
        check("t2_stall_data", 32'(m0_data), 107);
        check("t2_stall_valid", 32'(m0_valid), 1);
      end
      if (j == 15) check("t2_resume_data", 32'(m0_data), 108);
    end
    cke = 1'b1;
    param_latency = LW'(2);
    idle(4);

    // Frame A at latency 2, request 7 mid-frame
    for (int i = 0; i < 12; i++) begin
      if (i == 5) param_latency = LW'(7);
      drive(1, 1, (i < 4), (i >= 8), (i % 4 == 0), (i % 4 == 3), 150 + i);
      step();
      if (i == 0) check("t3_a_lat", 32'(cur0), 2);
      if (i == 6) check("t3_mid_lat", 32'(cur0), 2);
    end
    idle(2);
    check("t3_gap_lat", 32'(cur0), 2);
    // Frame B start applies latency 7
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, (i < 4), 0, (i % 4 == 0), (i % 4 == 3), 200 + i);
      step();
      if (i == 0) check("t3_b_lat", 32'(cur0), 7);
      if (i < 6) check("t3_flush_valid", 32'(m0_valid), 0);
      if (i == 6) begin
        check("t3_b_valid", 32'(m0_valid), 1);
        check("t3_b_data", 32'(m0_data), 200);
        check("t3_b_rowfirst", 32'(m0_rf), 1);
        check("t3_b_colfirst", 32'(m0_cf), 1);
      end
    end
    idle(8);

    // Clamp: 0 -> 1, 31 -> 16
    param_latency = LW'(0);
    drive(1, 1, 1, 0, 1, 0, 10);
    step();
    check("t4_lat_min", 32'(cur0), 1);
    check("t4_min_data", 32'(m0_data), 10);
    check("t4_min_valid", 32'(m0_valid), 1);
    param_latency = LW'(31);
    drive(1, 1, 1, 0, 1, 0, 20);
    step();
    check("t4_lat_max", 32'(cur0), 16);
    for (int j = 1; j < 16; j++) begin
      drive(1, 1, 0, 0, 0, 0, 20 + j);
      step();
      if (j == 14) check("t4_max_pre_valid", 32'(m0_valid), 0);
      if (j == 15) begin
        check("t4_max_valid", 32'(m0_valid), 1);
        check("t4_max_data", 32'(m0_data), 20);
      end
    end
    idle(16);

    // Gating: de=1 with valid=0
    param_latency = LW'(2);
    drive(1, 1, 1, 0, 1, 0, 30);
    step();
    drive(0, 1, 0, 0, 0, 0, 31);
    step();
    check("t5_lat", 32'(cur0), 2);
    check("t5_valid_de0", 32'(m0_de), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t5_gated_de", 32'(m0_de), 0);
    check("t5_gated_valid", 32'(m0_valid), 0);
    check("t5_raw_de", 32'(m1_de), 1);
    check("t5_raw_valid", 32'(m1_valid), 0);
    check("t5_raw_data", 32'(m1_data), 31);
    idle(4);

    // Reset mid-stream at latency 5
    param_latency = LW'(5);
    for (int j = 0; j < 8; j++) begin
      drive(1, 1, (j == 0), 0, (j == 0), 0, 40 + j);
      step();
      if (j == 5) check("t6_pre_data", 32'(m0_data), 41);
    end
    reset = 1'b1;
    drive(1, 1, 1, 0, 1, 0, 99);
    step();
    reset = 1'b0;
    check("t6_rst_valid", 32'(m0_valid), 0);
    check("t6_rst_lat", 32'(cur0), INIT);
    for (int j = 0; j < 10; j++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      check("t6_no_stale", 32'(m0_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jelly2_img_delay_var.md
Name: jelly2_img_delay_var

Overview:
- Runtime-programmable delay line for the jelly2 image stream: carries the frame flags, pixel data and user sideband through a delay of L clock-enabled cycles.
- L is set by a register at run time, from 1 to MAX_LATENCY.
- Used to re-align a bypass path against processing pipelines whose latency changes with mode.
- Latency changes are frame-synchronous, so an image is never split across two latencies.

Parameters:
- USER_WIDTH, 0, user sideband width; 0 means no sideband. USER_BITS = max(USER_WIDTH,1).
- DATA_WIDTH, 8, pixel data width.
- MAX_LATENCY, 16, maximum delay in cke cycles; must be at least 1.
- LATENCY_WIDTH, $clog2(MAX_LATENCY+1), width of the latency ports.
- INIT_LATENCY, 1, active latency after reset.
- USE_VALID, 0, output flag gating. 0: flags and de are ANDed with m_img_valid. 1: flags and de pass raw.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cke  in  1  clock enable; all state holds when low
- param_latency  in  LATENCY_WIDTH  requested latency
- current_latency  out  LATENCY_WIDTH  active latency
- s_img_row_first, s_img_row_last, s_img_col_first, s_img_col_last, s_img_de  in  1 each  input frame flags
- s_img_data  in  DATA_WIDTH  input pixel
- s_img_user  in  USER_BITS  input sideband
- s_img_valid  in  1  input sample valid
- m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last, m_img_de  out  1 each  delayed frame flags
- m_img_data  out  DATA_WIDTH  delayed pixel
- m_img_user  out  USER_BITS  delayed sideband
- m_img_valid  out  1  delayed valid

Behaviour:
- Clock and reset: one clock clk. Reset is synchronous and active-high; it acts on a clk edge regardless of cke.
- Reset state:
  - current_latency = clamp(INIT_LATENCY).
  - All stored valid bits = 0, so m_img_valid = 0 and the gated flags = 0.
  - m_img_data and m_img_user are don't-care (x allowed).
  - Write pointer = 0.
- Clamp rule: clamp(v) = 1 if v = 0; MAX_LATENCY if v > MAX_LATENCY; otherwise v.
- Delay semantics:
  - With active latency L, a sample presented at cke edge k appears on the m_* outputs immediately after cke edge k+L-1.
  - This is identical to an L-stage register pipeline. All outputs are registered; there is no combinational path from s_* to m_*.
  - Only edges with cke = 1 count. With cke = 0, outputs and state are frozen.
- Storage: a circular buffer of MAX_LATENCY entries plus an output register.
  - Valid bits live in resettable flops. Data and user bits may be in distributed RAM.
  - Write pointer wraps from MAX_LATENCY-1 to 0.
  - Read index = write pointer - (L-1), taken modulo MAX_LATENCY.
- Latency update:
  - An update edge is a cke edge where s_img_valid & s_img_de & s_img_row_first & s_img_col_first = 1 and clamp(param_latency) != current_latency.
  - At that edge:
    - current_latency takes the new value L'.
    - Every stored valid bit and the output valid register are cleared (flush).
    - The incoming frame-start sample is written normally.
  - Result: m_img_valid = 0 for the next L'-1 cke cycles, then the frame-start sample emerges on the L'-th.
  - Tail samples of the previous frame still in flight are discarded. Upstream must leave at least L_old cycles between frames.
  - param_latency changes outside frame start have no effect. An equal value produces no flush.
- USE_VALID = 0: m_img_{row,col}_{first,last} and m_img_de are ANDed with m_img_valid. Data and user are not gated.
- USE_VALID = 1: all fields pass raw.
- Simultaneous reset and frame start: reset wins and the sample is dropped.
- MAX_LATENCY = 1: pure single register; the update logic is a no-op.

Test Plan:
- Fixed latency: reset, param_latency = 4, cke = 1, ramp s_img_data 0,1,2… with valid = 1. Required: m_img_valid rises 4 edges after the first sample, data matches the input delayed by 4, no gaps across pointer wrap (run ≥ 3×MAX_LATENCY).
- cke stall: L = 3, drop cke for 5 cycles mid-stream. Required: outputs frozen; the sequence resumes with no loss or duplication; delay counted in cke edges only.
- Frame-synchronous change: frame A at L = 2; set param_latency = 7 mid-frame. Required: current_latency stays 2 until frame B start. At B start: flush, m_img_valid = 0 for 6 cycles, B's first pixel (row_first = col_first = 1) out on the 7th.
- Clamp: param_latency = 0 gives current_latency = 1; param_latency = 31 with MAX_LATENCY = 16 gives 16. Check latency by measurement.
- Gating: USE_VALID = 0 with valid = 0 and de = 1 input gives m_img_de = 0. Same stimulus with USE_VALID = 1 gives m_img_de = 1, valid = 0.
- Reset mid-stream: assert reset for 1 cycle while valid data is in flight at L = 5. Required: m_img_valid = 0 on the next cycle, current_latency = INIT_LATENCY, no stale sample emerges afterwards.
